shift_pipe: RTL
===============

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter: TAG_W, default 4, width of the user tag carried alongside each operation.
REQ-003 Derived constant: LEVELS = log2(WIDTH), the number of shift levels and pipeline stages (5 at WIDTH=32).
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous and active-low.
REQ-006 Port: in_valid  in  1  an operation is presented this cycle.
REQ-007 Port: in_ready  out  1  the pipeline accepts an operation this cycle.
REQ-008 Port: in_a  in  WIDTH  operand to be shifted.
REQ-009 Port: in_amt  in  WIDTH  shift amount, full word.
REQ-010 Port: in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 Port: in_tag  in  TAG_W  user tag, returned unchanged with the result.
REQ-012 Port: out_valid  out  1  the result is present.
REQ-013 Port: out_ready  in  1  the consumer takes the result this cycle.
REQ-014 Port: out_data  out  WIDTH  shifted result.
REQ-015 Port: out_tag  out  TAG_W  tag of the result.
REQ-016 Port: out_ovf  out  1  SLL lost at least one 1 bit; 0 for all other modes.
REQ-017 Port: busy  out  1  at least one pipeline stage holds a valid operation.

Function
REQ-018 Accept: an operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 Stall definition: stall = out_valid AND NOT out_ready.
REQ-020 Ready rule: in_ready SHALL equal NOT stall and SHALL be combinational from out_valid and out_ready only.
REQ-021 Structure: the block SHALL implement LEVELS registered stages.
REQ-022 Stage k (k = 0..LEVELS-1) SHALL conditionally shift by 2^k, selected by bit k of in_amt.
REQ-023 Each stage SHALL carry valid, data, the remaining amount bits, op, tag, an out-of-range flag and an ovf accumulator.
REQ-024 Latency: an operation accepted at the edge ending cycle 0 SHALL present out_valid=1 in cycle LEVELS when there is no stall.
REQ-025 Throughput: with no stall, the block SHALL sustain one accepted operation per cycle.
REQ-026 Stall behaviour: while stall=1, all stages SHALL hold; no accept occurs and no data is lost or duplicated.
REQ-027 Bubbles: bubbles SHALL NOT be compressed during a stall; the whole pipeline freezes.
REQ-028 Out-of-range amount: range = OR of in_amt[WIDTH-1:LEVELS], captured at accept.
REQ-029 If range=1, the result SHALL be 0 for SLL and SRL, and WIDTH copies of in_a[WIDTH-1] for SRA.
REQ-030 If range=1, ROL SHALL ignore the upper bits and rotate by in_amt[LEVELS-1:0].
REQ-031 Fill rules: SLL and SRL SHALL fill with 0; SRA SHALL fill with the original sign bit; ROL SHALL wrap bits shifted out of the MSB into the LSB.
REQ-032 out_ovf: for SLL, out_ovf SHALL be 1 iff any 1 bit of in_a was shifted out, including all ones when range=1 and in_a is nonzero.
REQ-033 out_ovf SHALL be 0 for SRL, SRA and ROL.
REQ-034 Amount zero: with in_amt = 0, out_data SHALL equal in_a in every mode, and out_ovf SHALL be 0.
REQ-035 Ordering: results SHALL emerge in acceptance order, each paired with its own tag.
REQ-036 Output stability: out_data, out_tag and out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-037 busy SHALL be the OR of all stage valid bits and SHALL be registered-derived (no combinational input path).

Reset
REQ-038 Reset flush: when rst_n=0 at a rising edge, every stage valid bit, out_valid and busy SHALL be 0 in the following cycle.
REQ-039 Reset values: out_data SHALL be 0, out_tag SHALL be 0, out_ovf SHALL be 0, and in_ready SHALL be 1 after reset.
REQ-040 Reset mid-operation: in-flight operations SHALL be discarded with no later out_valid pulse for them.
REQ-041 Reset priority: an accept attempted on the reset edge SHALL be ignored.

Verification (WIDTH=32, TAG_W=4)
REQ-042 SLL, a=0x0000_0001, amt=31, tag=3, accepted in cycle 0 -> cycle 5: out_valid=1, out_data=0x8000_0000, out_tag=3, out_ovf=0.
REQ-043 SRA, a=0x8000_0000, amt=4 -> 0xF800_0000.
REQ-044 SRA, same a, amt=0x20 -> 0xFFFF_FFFF.
REQ-045 SRL, a=0xFFFF_FFFF, amt=0x20 -> 0x0000_0000.
REQ-046 ROL, a=0x8000_0001, amt=0x21 -> 0x0000_0003.
REQ-047 SLL, a=0xC000_0000, amt=1 -> 0x8000_0000, out_ovf=1.
REQ-048 Backpressure: 8 back-to-back ops with tags 0..7, out_ready=0 during cycles 5-7 -> in_ready=0 during cycles 5-7.
REQ-049 Backpressure, continued: tags emerge in order 0..7 with none dropped or repeated, and outputs are held during the stall.
REQ-050 Reset mid-operation: 3 ops in flight, rst_n=0 for one edge -> next cycle out_valid=0, busy=0, in_ready=1, and no result appears within the next 10 cycles.

Source files
------------

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//   Pipelined barrel shifter. There is one registered stage per bit of the
//   shift amount. Stage k shifts by 2^k when amount bit k is set. The supported
//   modes are logical left, logical right, arithmetic right and rotate left.
//   A user tag travels with each operation.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. Producers hold valid and payload until that edge. While
//   out_valid=1 and out_ready=0 (stall), every stage holds its contents, so
//   in_ready is low and the output payload stays stable.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid / in_ready         operation handshake
//   in_a, in_amt, in_op, in_tag operand, full-word amount, mode, user tag
//                               (in_op: 00 SLL, 01 SRL, 10 SRA, 11 ROL)
//   out_valid / out_ready       result handshake
//   out_data, out_tag, out_ovf  result, its tag, SLL lost-ones flag
//   busy                        some stage holds a valid operation
// -----------------------------------------------------------------------------
module shift_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_amt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ovf,
   output logic             busy
);

   localparam int LEVELS = $clog2(WIDTH);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // Chain entry k is the input of stage k. Entry k+1 is the register of stage k.
   logic             c_valid [LEVELS+1];
   logic [WIDTH-1:0] c_data  [LEVELS+1];
   logic [TAG_W-1:0] c_tag   [LEVELS+1];
   logic             c_ovf   [LEVELS+1];
   // The last stage does not register these fields, because nothing reads them
   // after the final shift.
   logic [LEVELS-1:0] c_amt   [LEVELS];
   logic [1:0]        c_op    [LEVELS];
   logic              c_range [LEVELS];

   logic stall;
   logic advance;
   logic accept;

   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;

   // Front end. Amount bits above the level count make the amount
   // out-of-range. For SLL, an out-of-range amount loses every 1 bit of the
   // operand, so the overflow flag is decided here. The data override itself
   // is applied in the last stage.
   assign c_valid[0] = accept;
   assign c_data[0]  = in_a;
   assign c_tag[0]   = in_tag;
   assign c_amt[0]   = in_amt[LEVELS-1:0];
   assign c_op[0]    = in_op;
   assign c_range[0] = |in_amt[WIDTH-1:LEVELS];
   assign c_ovf[0]   = (|in_amt[WIDTH-1:LEVELS]) & (in_op == OP_SLL) & (|in_a);

   for (genvar k = 0; k < LEVELS; k++) begin : g_stage
      localparam int SH = 1 << k;

      logic             take;
      logic [WIDTH-1:0] shifted;
      logic             lost;
      logic [WIDTH-1:0] nxt_data;
      logic             nxt_ovf;

      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;
      logic             ovf_q;

      // The amount is shifted down one bit per stage, so bit 0 always selects
      // this stage's shift.
      assign take = c_amt[k][0];

      always_comb begin
         shifted = c_data[k];
         lost    = 1'b0;
         case (c_op[k])
            OP_SLL: begin
               shifted = c_data[k] << SH;
               lost    = |(c_data[k] >> (WIDTH - SH));
            end
            OP_SRL: shifted = c_data[k] >> SH;
            // Arithmetic right shift keeps the MSB. The original sign bit
            // therefore survives through every stage.
            OP_SRA: shifted = $unsigned($signed(c_data[k]) >>> SH);
            default: shifted = (c_data[k] << SH) | (c_data[k] >> (WIDTH - SH));
         endcase
         nxt_data = take ? shifted : c_data[k];
         nxt_ovf  = c_ovf[k] | (take & lost);
         // Out-of-range override. Only the last stage applies it. ROL ignores
         // the upper amount bits.
         if ((k == LEVELS - 1) && c_range[k] && (c_op[k] != OP_ROL)) begin
            nxt_data = (c_op[k] == OP_SRA) ? {WIDTH{c_data[k][WIDTH-1]}} : '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            ovf_q   <= 1'b0;
         end else if (advance) begin
            valid_q <= c_valid[k];
            data_q  <= nxt_data;
            tag_q   <= c_tag[k];
            ovf_q   <= nxt_ovf;
         end
      end

      assign c_valid[k+1] = valid_q;
      assign c_data[k+1]  = data_q;
      assign c_tag[k+1]   = tag_q;
      assign c_ovf[k+1]   = ovf_q;

      if (k < LEVELS - 1) begin : g_carry
         logic [LEVELS-1:0] amt_q;
         logic [1:0]        op_q;
         logic              range_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               amt_q   <= '0;
               op_q    <= OP_SLL;
               range_q <= 1'b0;
            end else if (advance) begin
               amt_q   <= c_amt[k] >> 1;
               op_q    <= c_op[k];
               range_q <= c_range[k];
            end
         end

         assign c_amt[k+1]   = amt_q;
         assign c_op[k+1]    = op_q;
         assign c_range[k+1] = range_q;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 1; i <= LEVELS; i++) begin
         busy = busy | c_valid[i];
      end
   end

   assign out_valid = c_valid[LEVELS];
   assign out_data  = c_data[LEVELS];
   assign out_tag   = c_tag[LEVELS];
   assign out_ovf   = c_ovf[LEVELS];

endmodule
